// File: rtl/uart_rx_buffered.sv
// uart_rx_buffered
// Oversampling UART receiver. The serial line is synchronized, each bit is
// decided by a three-sample majority vote around the bit centre, and every
// completed frame is pushed as {ferr, perr, data} into a small receive FIFO.
// Frame format (data bits, parity, stop bits, prescale) is captured at the
// start edge and held for the whole frame. An all-zero frame through the first
// stop bit is reported as a break instead of being stored.

module uart_rx_buffered #(
    parameter int DWIDTH     = 8,
    parameter int PWIDTH     = 6,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_data,
    input  logic [3:0]        data_bits,
    input  logic              parity_en,
    input  logic              parity_type,
    input  logic              stop_bits,
    input  logic [PWIDTH-1:0] prescale,
    output logic [DWIDTH-1:0] m_data,
    output logic              m_perr,
    output logic              m_ferr,
    output logic              m_valid,
    input  logic              m_ready,
    output logic              overrun,
    output logic              break_det,
    output logic              busy
);

    localparam int                AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0]       DEPTH_CNT = (AW + 1)'(FIFO_DEPTH);
    localparam logic [AW:0]       CNT_ONE   = (AW + 1)'(1);
    localparam logic [AW-1:0]     PTR_ONE   = AW'(1);
    localparam logic [PWIDTH-1:0] P_ONE     = PWIDTH'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP1,
        S_STOP2
    } state_t;

    typedef struct packed {
        logic              ferr;
        logic              perr;
        logic [DWIDTH-1:0] data;
    } entry_t;

    // Line synchronizer and edge history
    logic sync1_q, sync2_q, prev_q;
    logic line, line_fall;

    // Receiver state
    state_t            state_q, state_d;
    logic [PWIDTH-1:0] cnt_q, cnt_d;
    logic [3:0]        bit_idx_q, bit_idx_d;
    logic              smp0_q, smp0_d;
    logic              smp1_q, smp1_d;

    // Frame format captured at the start edge
    logic [3:0]        nbits_q, nbits_d;
    logic              pen_q, pen_d;
    logic              ptype_q, ptype_d;
    logic              stop2_q, stop2_d;
    logic [PWIDTH-1:0] presc_q, presc_d;

    // Frame accumulation
    logic [DWIDTH-1:0] shift_q, shift_d;
    logic              perr_q, perr_d;
    logic              ferr_q, ferr_d;
    logic              zero_q, zero_d;

    // Hand-off to the FIFO and event pulses
    logic   wr_req_q, wr_req_d;
    entry_t wr_word_q, wr_word_d;
    logic   break_q, break_d;
    logic   overrun_q, overrun_d;

    // Bit timing decode
    logic [PWIDTH-1:0] half, half_m1, half_p1, last;
    logic              decide, bit_end, maj;

    // FIFO
    entry_t        mem_q [FIFO_DEPTH];
    entry_t        head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          full, push, pop;

    // Two-flop synchronizer plus one history flop for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            prev_q  <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments keep this a real three-stage chain;
            // blocking ones would collapse it into a single flop.
            sync1_q <= s_data;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign line      = sync2_q;
    assign line_fall = prev_q & ~sync2_q;

    // Sample points and bit boundary derived from the latched prescale
    always_comb begin
        half    = presc_q >> 1;
        half_m1 = half - P_ONE;
        half_p1 = half + P_ONE;
        last    = presc_q - P_ONE;
        decide  = (cnt_q == half_p1);
        bit_end = (cnt_q == last);
        maj     = (smp0_q & smp1_q) | (smp0_q & line) | (smp1_q & line);
    end

    // Next-state logic: bit timing, frame assembly, break and write decisions
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case can leave a latch behind.
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        smp0_d    = smp0_q;
        smp1_d    = smp1_q;
        nbits_d   = nbits_q;
        pen_d     = pen_q;
        ptype_d   = ptype_q;
        stop2_d   = stop2_q;
        presc_d   = presc_q;
        shift_d   = shift_q;
        perr_d    = perr_q;
        ferr_d    = ferr_q;
        zero_d    = zero_q;
        wr_req_d  = 1'b0;
        wr_word_d = wr_word_q;
        break_d   = 1'b0;

        if (state_q != S_IDLE) begin
            cnt_d = bit_end ? '0 : cnt_q + P_ONE;
            if (cnt_q == half_m1) smp0_d = line;
            if (cnt_q == half)    smp1_d = line;
        end

        case (state_q)
            S_IDLE: begin
                if (line_fall) begin
                    // The detect cycle is count 0 of the start bit.
                    state_d   = S_START;
                    cnt_d     = P_ONE;
                    bit_idx_d = '0;
                    nbits_d   = data_bits;
                    pen_d     = parity_en;
                    ptype_d   = parity_type;
                    stop2_d   = stop_bits;
                    presc_d   = prescale;
                    shift_d   = '0;
                    perr_d    = 1'b0;
                    ferr_d    = 1'b0;
                    zero_d    = 1'b1;
                end
            end

            S_START: begin
                if (bit_end) state_d = S_DATA;
                // A start bit that votes high was only a glitch.
                if (decide && maj) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            end

            S_DATA: begin
                if (decide) begin
                    for (int i = 0; i < DWIDTH; i++) begin
                        if (bit_idx_q == 4'(i)) shift_d[i] = maj;
                    end
                    zero_d = zero_q & ~maj;
                end
                if (bit_end) begin
                    if (bit_idx_q == nbits_q - 4'd1) begin
                        bit_idx_d = '0;
                        state_d   = pen_q ? S_PARITY : S_STOP1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end

            S_PARITY: begin
                if (decide) begin
                    // Unused upper data bits are zero, so they do not disturb the XOR.
                    perr_d = (((^shift_q) ^ maj) != ptype_q);
                    zero_d = zero_q & ~maj;
                end
                if (bit_end) state_d = S_STOP1;
            end

            S_STOP1: begin
                if (bit_end) state_d = S_STOP2;
                if (decide) begin
                    if (zero_q && !maj) begin
                        break_d = 1'b1;
                        state_d = S_IDLE;
                        cnt_d   = '0;
                    end else if (!stop2_q) begin
                        wr_req_d       = 1'b1;
                        wr_word_d.ferr = ferr_q | ~maj;
                        wr_word_d.perr = perr_q;
                        wr_word_d.data = shift_q;
                        state_d        = S_IDLE;
                        cnt_d          = '0;
                    end else begin
                        ferr_d = ferr_q | ~maj;
                    end
                end
            end

            S_STOP2: begin
                // Leave at the decision point so a back-to-back start edge is caught.
                if (decide) begin
                    wr_req_d       = 1'b1;
                    wr_word_d.ferr = ferr_q | ~maj;
                    wr_word_d.perr = perr_q;
                    wr_word_d.data = shift_q;
                    state_d        = S_IDLE;
                    cnt_d          = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Receiver registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            smp0_q    <= 1'b1;
            smp1_q    <= 1'b1;
            nbits_q   <= '0;
            pen_q     <= 1'b0;
            ptype_q   <= 1'b0;
            stop2_q   <= 1'b0;
            presc_q   <= '0;
            shift_q   <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            zero_q    <= 1'b0;
            wr_req_q  <= 1'b0;
            wr_word_q <= '0;
            break_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            smp0_q    <= smp0_d;
            smp1_q    <= smp1_d;
            nbits_q   <= nbits_d;
            pen_q     <= pen_d;
            ptype_q   <= ptype_d;
            stop2_q   <= stop2_d;
            presc_q   <= presc_d;
            shift_q   <= shift_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            zero_q    <= zero_d;
            wr_req_q  <= wr_req_d;
            wr_word_q <= wr_word_d;
            break_q   <= break_d;
        end
    end

    // FIFO control: a write into a full FIFO survives only if the head pops
    always_comb begin
        full      = (count_q == DEPTH_CNT);
        pop       = m_valid & m_ready;
        push      = wr_req_q & (~full | pop);
        overrun_d = wr_req_q & full & ~pop;
        wr_ptr_d  = push ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d  = pop  ? rd_ptr_q + PTR_ONE : rd_ptr_q;
        count_d   = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    // FIFO pointers, occupancy and overrun pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // FIFO storage
    // NOTE: the storage array is not reset; m_valid gates the head so stale
    // contents are never visible.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word_q;
    end

    // Head presentation, forced to zero while the FIFO is empty
    always_comb begin
        head    = mem_q[rd_ptr_q];
        m_valid = (count_q != '0);
        m_data  = '0;
        m_perr  = 1'b0;
        m_ferr  = 1'b0;
        if (m_valid) begin
            m_data = head.data;
            m_perr = head.perr;
            m_ferr = head.ferr;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;
    assign break_det = break_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// tb_uart_rx_buffered
// Directed bench for uart_rx_buffered: drives serial frames bit by bit and
// compares the FIFO head and event pulses against hand-computed values.

`timescale 1ns/1ps

module tb_uart_rx_buffered;

    localparam int DW = 8;
    localparam int PW = 6;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          s_data;
    logic [3:0]    data_bits;
    logic          parity_en;
    logic          parity_type;
    logic          stop_bits;
    logic [PW-1:0] prescale;
    logic [DW-1:0] m_data;
    logic          m_perr;
    logic          m_ferr;
    logic          m_valid;
    logic          m_ready;
    logic          overrun;
    logic          break_det;
    logic          busy;

    int n_cmp   = 0;
    int n_mis   = 0;
    int ovr_cnt = 0;
    int brk_cnt = 0;
    int ovr0;
    int brk0;
    int n;
    int t;

    always #5 clk = ~clk;

    uart_rx_buffered #(
        .DWIDTH    (DW),
        .PWIDTH    (PW),
        .FIFO_DEPTH(FD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_data     (s_data),
        .data_bits  (data_bits),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .stop_bits  (stop_bits),
        .prescale   (prescale),
        .m_data     (m_data),
        .m_perr     (m_perr),
        .m_ferr     (m_ferr),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .overrun    (overrun),
        .break_det  (break_det),
        .busy       (busy)
    );

    // Pulse counters, sampled away from the active edge
    always @(negedge clk) begin
        if (overrun === 1'b1)   ovr_cnt++;
        if (break_det === 1'b1) brk_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bit_time(input logic v, input int p);
        s_data = v;
        repeat (p) @(negedge clk);
    endtask

    task automatic cfg_8n1(input int p);
        data_bits   = 4'd8;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop_bits   = 1'b0;
        prescale    = PW'(p);
    endtask

    // Sends one frame; format inputs are scrambled after the start bit to
    // show they only matter at the start edge.
    task automatic send_frame(input logic [8:0] d, input int nb, input logic pen,
                              input logic ptype, input logic pbit, input logic two,
                              input logic st1, input logic st2, input int p);
        data_bits   = 4'(nb);
        parity_en   = pen;
        parity_type = ptype;
        stop_bits   = two;
        prescale    = PW'(p);
        bit_time(1'b0, p);
        data_bits   = (nb == 5) ? 4'd8 : 4'd5;
        parity_en   = ~pen;
        parity_type = ~ptype;
        stop_bits   = ~two;
        prescale    = (p == 4) ? PW'(20) : PW'(4);
        for (int i = 0; i < nb; i++) bit_time(d[i], p);
        if (pen) bit_time(pbit, p);
        bit_time(st1, p);
        if (two) bit_time(st2, p);
        s_data = 1'b1;
    endtask

    task automatic send8(input logic [7:0] d);
        send_frame({1'b0, d}, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8);
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (m_valid !== 1'b1 && k < 400) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_valid"}, 32'(m_valid), 32'd1);
    endtask

    task automatic pop_check(input string tag, input logic [7:0] d, input logic pe, input logic fe);
        wait_valid(tag);
        check({tag, "_data"}, 32'(m_data), 32'(d));
        check({tag, "_perr"}, 32'(m_perr), 32'(pe));
        check({tag, "_ferr"}, 32'(m_ferr), 32'(fe));
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
    endtask

    // Hard stop in case something hangs
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst     = 1'b1;
        s_data  = 1'b1;
        m_ready = 1'b0;
        cfg_8n1(8);
        repeat (4) @(negedge clk);
        check("rst_outs", 32'({m_valid, m_data, m_perr, m_ferr, overrun, break_det, busy}), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_valid", 32'(m_valid), 32'd0);
        check("idle_busy", 32'(busy), 32'd0);

        // 0xA5, 8N1: held until m_ready
        send8(8'hA5);
        wait_valid("a5");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("a5_hold_data", 32'(m_data), 32'hA5);
            check("a5_hold_valid", 32'(m_valid), 32'd1);
        end
        check("a5_perr", 32'(m_perr), 32'd0);
        check("a5_ferr", 32'(m_ferr), 32'd0);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        check("a5_empty_after_pop", 32'(m_valid), 32'd0);

        // 5 bits, odd parity, correct parity bit: 0x13 has three ones -> p=0
        send_frame(9'h013, 5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8);
        pop_check("odd5", 8'h13, 1'b0, 1'b0);

        // 7 bits, even parity, wrong parity bit, two stop bits
        send_frame(9'h035, 7, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 8);
        pop_check("even7", 8'h35, 1'b1, 1'b0);

        // Two stop bits, second one low -> framing error
        send_frame(9'h0C3, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8);
        pop_check("stop2_low", 8'hC3, 1'b0, 1'b1);

        // One stop bit low with non-zero data -> framing error, not a break
        brk0 = brk_cnt;
        send_frame(9'h081, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8);
        pop_check("stop1_low", 8'h81, 1'b0, 1'b1);

        // All-zero data with a good stop bit is an ordinary entry
        send8(8'h00);
        pop_check("zero_data", 8'h00, 1'b0, 1'b0);

        // Zero data, parity bit 1 (even -> perr), stop low: not a break
        send_frame(9'h000, 8, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8);
        pop_check("zero_par1", 8'h00, 1'b1, 1'b1);
        repeat (4) @(negedge clk);
        check("no_break_yet", 32'(brk_cnt - brk0), 32'd0);

        // Minimum prescale
        send_frame(9'h096, 8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4);
        pop_check("p4", 8'h96, 1'b0, 1'b0);

        // Two-cycle low glitch at prescale 16
        cfg_8n1(16);
        repeat (4) @(negedge clk);
        ovr0 = ovr_cnt;
        brk0 = brk_cnt;
        s_data = 1'b0;
        repeat (2) @(negedge clk);
        s_data = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("glitch_busy_rise", 32'(busy), 32'd1);
        t = 0;
        while (busy !== 1'b0 && t < 40) begin
            @(negedge clk);
            t++;
        end
        check("glitch_busy_fall_lt12", 32'(t < 12), 32'd1);
        repeat (40) @(negedge clk);
        check("glitch_no_entry", 32'(m_valid), 32'd0);
        check("glitch_no_break", 32'(brk_cnt - brk0), 32'd0);
        check("glitch_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);

        // Fill the FIFO, overflow once, then a write that coincides with a pop
        ovr0 = ovr_cnt;
        for (int i = 1; i <= 4; i++) send8(8'(i));
        repeat (10) @(negedge clk);
        check("fill_no_ovr", 32'(ovr_cnt - ovr0), 32'd0);
        send8(8'h05);
        repeat (10) @(negedge clk);
        check("ovr_once", 32'(ovr_cnt - ovr0), 32'd1);
        check("full_head", 32'(m_data), 32'h01);
        fork
            send8(8'h06);
            begin
                n = 0;
                while (busy !== 1'b1 && n < 200) begin
                    @(negedge clk);
                    n++;
                end
                while (busy !== 1'b0 && n < 400) begin
                    @(negedge clk);
                    n++;
                end
                m_ready = 1'b1;
                @(negedge clk);
                m_ready = 1'b0;
            end
        join
        repeat (10) @(negedge clk);
        check("pop_push_no_ovr", 32'(ovr_cnt - ovr0), 32'd1);
        pop_check("fifo2", 8'h02, 1'b0, 1'b0);
        pop_check("fifo3", 8'h03, 1'b0, 1'b0);
        pop_check("fifo4", 8'h04, 1'b0, 1'b0);
        pop_check("fifo6", 8'h06, 1'b0, 1'b0);
        check("fifo_drained", 32'(m_valid), 32'd0);

        // Line low for 12 bit times -> single break, then a clean frame
        cfg_8n1(8);
        repeat (4) @(negedge clk);
        brk0 = brk_cnt;
        s_data = 1'b0;
        repeat (96) @(negedge clk);
        s_data = 1'b1;
        repeat (24) @(negedge clk);
        check("break_once", 32'(brk_cnt - brk0), 32'd1);
        check("break_no_entry", 32'(m_valid), 32'd0);
        send8(8'h3C);
        pop_check("after_break", 8'h3C, 1'b0, 1'b0);
        check("break_still_once", 32'(brk_cnt - brk0), 32'd1);

        // Reset in the middle of data bit 3, with an entry already queued
        send8(8'h77);
        wait_valid("pre_rst");
        cfg_8n1(8);
        bit_time(1'b0, 8);
        for (int i = 0; i < 3; i++) bit_time(1'b1, 8);
        s_data = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("midrst_outs", 32'({m_valid, m_data, m_perr, m_ferr, overrun, break_det, busy}), 32'd0);
        ovr0 = ovr_cnt;
        brk0 = brk_cnt;
        m_ready = 1'b1;
        repeat (120) @(negedge clk);
        m_ready = 1'b0;
        check("midrst_no_entry", 32'(m_valid), 32'd0);
        check("midrst_idle", 32'(busy), 32'd0);
        check("midrst_no_pulses", 32'((ovr_cnt - ovr0) + (brk_cnt - brk0)), 32'd0);
        send8(8'h5A);
        pop_check("after_rst", 8'h5A, 1'b0, 1'b0);
        repeat (2) @(negedge clk);
        check("final_empty", 32'(m_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
